// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative ALU.
//   - ALU_* opcode constants (same encoding as the single-cycle ALU, plus MUL)
//   - alu_state_t: IDLE / MUL / DONE controller states
//   - alu_flags_t: registered status flags presented with each result
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'h0;
  localparam logic [3:0] ALU_OR    = 4'h1;
  localparam logic [3:0] ALU_ADD   = 4'h2;
  localparam logic [3:0] ALU_LSL   = 4'h3;
  localparam logic [3:0] ALU_LSR   = 4'h4;
  localparam logic [3:0] ALU_ASR   = 4'h5;
  localparam logic [3:0] ALU_SUB   = 4'h6;
  localparam logic [3:0] ALU_PASSB = 4'h7;
  localparam logic [3:0] ALU_MUL   = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add unsigned multiplier, one step per clock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : latch a/b, clear counter and accumulator, begin WIDTH steps
//   a, b        : unsigned operands (sampled only when start=1)
//   done        : high during the cycle whose rising edge performs the last step
//   prod_lo     : low WIDTH bits of the product (valid while done=1)
//   prod_hi_nz  : upper WIDTH product bits are nonzero (valid while done=1)
// The product outputs are taken from the accumulator's next value so the
// caller can register the finished product on the same edge as the final step.
module seq_multiplier #(
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  logic [WIDTH-1:0]   r_a;
  // {partial high product, unconsumed multiplier bits / low product bits}
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;

  logic [WIDTH:0]     w_partial;
  logic [2*WIDTH-1:0] w_acc_next;

  // Add A into the high half when the current multiplier bit is set, then
  // shift the whole accumulator right; the carry-out lands in the top bit.
  assign w_partial  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_acc_next = {w_partial, r_acc[WIDTH-1:1]};

  assign done       = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign prod_lo    = w_acc_next[WIDTH-1:0];
  assign prod_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];

  // NOTE: the operand/accumulator datapath is reset too, so a discarded
  // multiply leaves no stale state behind and simulation never starts from X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_a    <= a;
      r_acc  <= {{WIDTH{1'b0}}, b};
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// iterative_alu: handshaked ALU with single-cycle logic/arith/shift ops and a
// WIDTH-cycle unsigned multiply.
//   CLK, Reset_L     : clock, asynchronous active-low reset
//   InValid/InReady  : operation handshake (BusA, BusB, ALUCtrl sampled on accept)
//   BusA, BusB       : operands (BusB low SHAMT_W bits are the shift amount)
//   ALUCtrl          : opcode (alu_pkg ALU_*)
//   OutValid/OutReady: result handshake
//   BusW             : registered result
//   Zero, Negative, Carry, Overflow, Err : registered flags for BusW
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Err
);

  alu_state_t       r_state;
  alu_state_t       w_next_state;
  logic [WIDTH-1:0] r_busw;
  alu_flags_t       r_flags;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0] w_result;
  alu_flags_t       w_flags;

  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_lo;
  logic             w_mul_hi_nz;
  alu_flags_t       w_mul_flags;

  assign w_accept = InValid && InReady;
  assign w_is_mul = (ALUCtrl == ALU_MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk        (CLK),
    .rst_n      (Reset_L),
    .start      (w_accept && w_is_mul),
    .a          (BusA),
    .b          (BusB),
    .done       (w_mul_done),
    .prod_lo    (w_mul_lo),
    .prod_hi_nz (w_mul_hi_nz)
  );

  // Shared adder: SUB is A + ~B + 1, so carry-out means "no borrow".
  assign w_is_sub  = (ALUCtrl == ALU_SUB);
  assign w_b_eff   = w_is_sub ? ~BusB : BusB;
  assign w_sum     = {1'b0, BusA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_add_ovf = (BusA[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != BusA[WIDTH-1]);
  assign w_shamt   = BusB[SHAMT_W-1:0];

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_result = '0;
    w_flags  = '0;
    unique case (ALUCtrl)
      ALU_AND:   w_result = BusA & BusB;
      ALU_OR:    w_result = BusA | BusB;
      ALU_ADD, ALU_SUB: begin
        w_result         = w_sum[WIDTH-1:0];
        w_flags.carry    = w_sum[WIDTH];
        w_flags.overflow = w_add_ovf;
      end
      ALU_LSL:   w_result = BusA << w_shamt;
      ALU_LSR:   w_result = BusA >> w_shamt;
      ALU_ASR:   w_result = WIDTH'($signed(BusA) >>> w_shamt);
      ALU_PASSB: w_result = BusB;
      default:   w_flags.err = 1'b1;  // illegal (MUL never uses this path)
    endcase
    w_flags.zero     = (w_result == '0);
    w_flags.negative = w_result[WIDTH-1];
  end

  always_comb begin
    w_mul_flags          = '0;
    w_mul_flags.zero     = (w_mul_lo == '0);
    w_mul_flags.negative = w_mul_lo[WIDTH-1];
    w_mul_flags.carry    = w_mul_hi_nz;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = w_is_mul ? MUL : DONE;
      MUL:  if (w_mul_done) w_next_state = DONE;
      DONE: begin
        if (OutReady) begin
          if (w_accept) w_next_state = w_is_mul ? MUL : DONE;
          else          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    InReady  = (r_state == IDLE) || ((r_state == DONE) && OutReady);
    OutValid = (r_state == DONE);
  end

  // Result/flag registers: loaded only when a result is produced, so they hold
  // steady under backpressure.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_busw  <= '0;
      r_flags <= '0;
    end else if (w_accept && !w_is_mul) begin
      r_busw  <= w_result;
      r_flags <= w_flags;
    end else if ((r_state == MUL) && w_mul_done) begin
      r_busw  <= w_mul_lo;
      r_flags <= w_mul_flags;
    end
  end

  assign BusW     = r_busw;
  assign Zero     = r_flags.zero;
  assign Negative = r_flags.negative;
  assign Carry    = r_flags.carry;
  assign Overflow = r_flags.overflow;
  assign Err      = r_flags.err;

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: randomized and directed checks of iterative_alu against an
// arithmetic reference model (wide sums/products, signed range test).
module tb_iterative_alu;

  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] w;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         err;
  } res_t;

  logic         CLK = 1'b0;
  logic         Reset_L;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] BusA, BusB;
  logic [3:0]   ALUCtrl;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] BusW;
  logic         Zero, Negative, Carry, Overflow, Err;

  int n_checks = 0;
  int n_fail   = 0;

  iterative_alu #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .Reset_L  (Reset_L),
    .InValid  (InValid),
    .InReady  (InReady),
    .BusA     (BusA),
    .BusB     (BusB),
    .ALUCtrl  (ALUCtrl),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .BusW     (BusW),
    .Zero     (Zero),
    .Negative (Negative),
    .Carry    (Carry),
    .Overflow (Overflow),
    .Err      (Err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the result is the true mathematical value truncated to W
  // bits; overflow means the true signed value does not fit in W bits.
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic [W:0]          s;
    logic signed [W+1:0] sv;
    logic signed [W+1:0] wext;
    logic [2*W-1:0]      p;
    logic [5:0]          amt;
    r   = '0;
    amt = b[5:0];
    case (op)
      4'h0: r.w = a & b;
      4'h1: r.w = a | b;
      4'h2: begin
        s   = {1'b0, a} + {1'b0, b};
        r.w = s[W-1:0];
        r.c = s[W];
        sv  = $signed(a) + $signed(b);
      end
      4'h6: begin
        r.w = a - b;
        r.c = (a >= b);
        sv  = $signed(a) - $signed(b);
      end
      4'h3: r.w = a << amt;
      4'h4: r.w = a >> amt;
      4'h5: r.w = $signed(a) >>> amt;
      4'h7: r.w = b;
      4'h8: begin
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r.w = p[W-1:0];
        r.c = (p[2*W-1:W] != 0);
      end
      default: r.err = 1'b1;
    endcase
    if (op == 4'h2 || op == 4'h6) begin
      wext = $signed(r.w);
      r.v  = (sv != wext);
    end
    r.z = (r.w == 0);
    r.n = r.w[W-1];
    return r;
  endfunction

  function automatic res_t observe();
    return {BusW, Zero, Negative, Carry, Overflow, Err};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return {$urandom, $urandom};
      1:       return W'($urandom_range(0, 255));
      2:       return 64'h8000_0000_0000_0000;
      3:       return '1;
      default: return 64'h7FFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Present one op, hold it through the accepting edge, then scramble the
  // inputs. Returns at the first falling edge after the accept.
  task automatic issue_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    InValid = 1'b1;
    ALUCtrl = op;
    BusA    = a;
    BusB    = b;
    @(posedge CLK);
    @(negedge CLK);
    InValid = 1'b0;
    ALUCtrl = 4'($urandom);
    BusA    = {$urandom, $urandom};
    BusB    = {$urandom, $urandom};
  endtask

  // Latency counted in falling edges after the accepting edge (1 = next cycle).
  task automatic wait_out(output int lat, output int ready_bad);
    lat       = 1;
    ready_bad = 0;
    while (!OutValid && lat < 200) begin
      if (InReady) ready_bad++;
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({OutValid, BusW, Zero, Negative, Carry, Overflow, Err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b w=%h z%b n%b c%b v%b e%b want all zero",
               OutValid, BusW, Zero, Negative, Carry, Overflow, Err);
    end
    n_checks++;
    if (InReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_inready: got %b want 1", InReady);
    end
  endtask

  task automatic run_single(input string name, input logic [3:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    res_t exp;
    res_t got;
    int   lat, rb, want_lat;
    exp      = model(op, a, b);
    want_lat = (op == 4'h8) ? W + 1 : 1;
    issue_op(op, a, b);
    wait_out(lat, rb);
    got = observe();
    n_checks++;
    if (lat !== want_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, want_lat);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_result: got w=%h zncve=%b want w=%h zncve=%b (op=%h a=%h b=%h)",
               name, got.w, {got.z, got.n, got.c, got.v, got.err},
               exp.w, {exp.z, exp.n, exp.c, exp.v, exp.err}, op, a, b);
    end
    if (op == 4'h8) begin
      n_checks++;
      if (rb !== 0) begin
        n_fail++;
        $display("FAIL %s_inready_busy: got %0d cycles with InReady=1 want 0", name, rb);
      end
    end
  endtask

  task automatic test_add_sub();
    OutReady = 1'b1;
    run_single("add_directed", 4'h2, 64'h1234, 64'hABCD_0000);
    run_single("sub_directed", 4'h6, 64'h1234, 64'hABCD_0000);
    run_single("sub_equal",    4'h6, 64'h1111, 64'h1111);
    run_single("add_ovf",      4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    for (int i = 0; i < 10; i++)
      run_single("addsub_rand", ($urandom_range(0, 1) != 0) ? 4'h2 : 4'h6,
                 pick_operand(), pick_operand());
  endtask

  task automatic test_shift_illegal();
    logic [W-1:0] b;
    OutReady = 1'b1;
    run_single("asr_directed", 4'h5, 64'h8000_0000_0000_0000, 64'h41);
    run_single("illegal_f",    4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    for (int i = 0; i < 9; i++) begin
      b = {$urandom, $urandom};
      run_single("shift_rand", 4'(3 + (i % 3)), pick_operand(), b);
    end
    for (int i = 0; i < 3; i++)
      run_single("illegal_rand", 4'($urandom_range(9, 15)), pick_operand(), pick_operand());
  endtask

  task automatic test_mul();
    OutReady = 1'b1;
    run_single("mul_directed", 4'h8, 64'h1234, 64'hABCD);
    run_single("mul_hi",       4'h8, 64'h8000_0000_0000_0000, 64'h4);
    for (int i = 0; i < 4; i++)
      run_single("mul_rand", 4'h8, pick_operand(), pick_operand());
  endtask

  task automatic test_backpressure();
    res_t held;
    res_t exp;
    int   lat, rb, bad;
    OutReady = 1'b0;
    issue_op(4'h2, pick_operand(), pick_operand());
    wait_out(lat, rb);
    held = observe();
    InValid = 1'b1;
    ALUCtrl = 4'h1;
    BusA    = 64'h1234;
    BusB    = 64'h0;
    exp     = model(4'h1, 64'h1234, 64'h0);
    bad     = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (observe() !== held || OutValid !== 1'b1 || InReady !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: got %0d unstable cycles want 0", bad);
    end
    OutReady = 1'b1;
    #1;
    n_checks++;
    if (InReady !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release_ready: got %b want 1", InReady);
    end
    @(posedge CLK);
    @(negedge CLK);
    InValid = 1'b0;
    n_checks++;
    if (OutValid !== 1'b1 || observe() !== exp) begin
      n_fail++;
      $display("FAIL backpressure_next: got valid=%b w=%h want valid=1 w=%h", OutValid, BusW, exp.w);
    end
  endtask

  task automatic test_back_to_back();
    res_t         exp;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    OutReady = 1'b1;
    for (int i = 0; i <= 24; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        n_checks++;
        if (OutValid !== 1'b1 || observe() !== exp) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got valid=%b w=%h want valid=1 w=%h", i, OutValid, BusW, exp.w);
        end
        n_checks++;
        if (InReady !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_inready[%0d]: got %b want 1", i, InReady);
        end
      end
      if (i == 24) begin
        InValid = 1'b0;
      end else begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'h8) op = 4'h7;
        a  = pick_operand();
        b  = pick_operand();
        InValid = 1'b1;
        ALUCtrl = op;
        BusA    = a;
        BusB    = b;
        exp     = model(op, a, b);
      end
    end
    @(negedge CLK);
    n_checks++;
    if (OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got OutValid=%b want 0", OutValid);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    OutReady = 1'b1;
    issue_op(4'h8, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (19) @(negedge CLK);
    Reset_L = 1'b0;
    #1;
    n_checks++;
    if ({OutValid, BusW, Zero, Negative, Carry, Overflow, Err} !== '0) begin
      n_fail++;
      $display("FAIL midmul_reset_outputs: got valid=%b w=%h want all zero", OutValid, BusW);
    end
    @(negedge CLK);
    Reset_L = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (OutValid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midmul_no_result: got %0d OutValid cycles want 0", seen);
    end
    run_single("passb_after_reset", 4'h7, {$urandom, $urandom}, 64'hABCD);
  endtask

  initial begin
    Reset_L  = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b1;
    ALUCtrl  = '0;
    BusA     = '0;
    BusB     = '0;
    repeat (3) @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);
    test_reset();
    test_add_sub();
    test_shift_illegal();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
